// File: rtl/pcie_req_arbiter.sv
// pcie_req_arbiter
// Round-robin arbiter sharing one PCIe request port between NUM_REQ
// requesters. One transaction is in flight at a time: the winner is
// accepted, its request is issued to the PCIe side, and the completion
// (or a timeout abort) is returned to that requester alone.
module pcie_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  pcie_req,
  output logic                  pcie_wr,
  output logic [31:0]           pcie_addr,
  output logic [31:0]           pcie_wdata,
  input  logic                  pcie_gnt,
  input  logic [31:0]           pcie_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             state_q,      state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   owner_q,      owner_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [NUM_REQ-1:0] req_ready_q,  req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q,  rsp_valid_d;
  logic [31:0]        rsp_rdata_q,  rsp_rdata_d;
  logic               rsp_err_q,    rsp_err_d;
  logic               pcie_req_q,   pcie_req_d;
  logic               pcie_wr_q,    pcie_wr_d;
  logic [31:0]        pcie_addr_q,  pcie_addr_d;
  logic [31:0]        pcie_wdata_q, pcie_wdata_d;

  // Arbitration result and the winner's request fields
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               win_wr;
  logic [31:0]        win_addr;
  logic [31:0]        win_wdata;
  int                 cand;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting just above the last served requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Select the winner's slice of the flattened request buses
  always_comb begin
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        win_wr    = req_wr[i];
        win_addr  = req_addr[32*i +: 32];
        win_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    pcie_req_d   = pcie_req_q;
    pcie_wr_d    = pcie_wr_q;
    pcie_addr_d  = pcie_addr_q;
    pcie_wdata_d = pcie_wdata_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          req_ready_d  = onehot(win_idx);
          owner_d      = win_idx;
          pcie_req_d   = 1'b1;
          pcie_wr_d    = win_wr;
          pcie_addr_d  = win_addr;
          pcie_wdata_d = win_wdata;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // A grant on the terminal-count cycle still completes normally
        if (pcie_gnt) begin
          pcie_req_d  = 1'b0;
          rsp_rdata_d = pcie_wr_q ? 32'h0 : pcie_rdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = onehot(owner_q);
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          pcie_req_d  = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = onehot(owner_q);
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        // Only the owner's rsp_ready can retire the response
        if (rsp_ready[owner_q]) begin
          rsp_valid_d  = '0;
          rsp_err_d    = 1'b0;
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        pcie_req_d  = 1'b0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async active-low reset
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      pcie_req_q   <= 1'b0;
      pcie_wr_q    <= 1'b0;
      pcie_addr_q  <= '0;
      pcie_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      pcie_req_q   <= pcie_req_d;
      pcie_wr_q    <= pcie_wr_d;
      pcie_addr_q  <= pcie_addr_d;
      pcie_wdata_q <= pcie_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign pcie_req   = pcie_req_q;
  assign pcie_wr    = pcie_wr_q;
  assign pcie_addr  = pcie_addr_q;
  assign pcie_wdata = pcie_wdata_q;

endmodule

// File: tb/tb_pcie_req_arbiter.sv
// Directed bench for pcie_req_arbiter (NUM_REQ=2, TIMEOUT=4).
module tb_pcie_req_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 4;

  logic                  axi_aclk = 1'b0;
  logic                  axi_aresetn;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_wr;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  pcie_req;
  logic                  pcie_wr;
  logic [31:0]           pcie_addr;
  logic [31:0]           pcie_wdata;
  logic                  pcie_gnt;
  logic [31:0]           pcie_rdata;

  int errors = 0;
  int checks = 0;

  pcie_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .axi_aclk   (axi_aclk),
    .axi_aresetn(axi_aresetn),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .pcie_req   (pcie_req),
    .pcie_wr    (pcie_wr),
    .pcie_addr  (pcie_addr),
    .pcie_wdata (pcie_wdata),
    .pcie_gnt   (pcie_gnt),
    .pcie_rdata (pcie_rdata)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    @(negedge axi_aclk);
  endtask

  task automatic do_reset();
    axi_aresetn = 1'b0;
    tick();
    axi_aresetn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_valid[i]         = 1'b1;
    req_wr[i]            = wr;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  // One full transaction: arbitration, grant after gwait cycles, response handshake
  task automatic txn(input string tag, input int owner, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int gwait, input logic [31:0] rd, input logic drop);
    tick();
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(1 << owner));
    chk({tag, ".pcie_req"}, 32'(pcie_req), 32'd1);
    chk({tag, ".pcie_wr"}, 32'(pcie_wr), 32'(wr));
    chk({tag, ".pcie_addr"}, pcie_addr, a);
    if (wr) chk({tag, ".pcie_wdata"}, pcie_wdata, d);
    if (drop) req_valid[owner] = 1'b0;
    repeat (gwait - 1) tick();
    pcie_gnt   = 1'b1;
    pcie_rdata = rd;
    tick();
    pcie_gnt = 1'b0;
    chk({tag, ".pcie_req_off"}, 32'(pcie_req), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1 << owner));
    chk({tag, ".rsp_rdata"}, rsp_rdata, wr ? 32'h0 : rd);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    rsp_ready        = '0;
    rsp_ready[owner] = 1'b1;
    tick();
    rsp_ready = '0;
    chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    axi_aresetn = 1'b0;
    req_valid   = '0;
    req_wr      = '0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = '0;
    pcie_gnt    = 1'b0;
    pcie_rdata  = '0;
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    chk("rst.pcie_req", 32'(pcie_req), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.pcie_addr", pcie_addr, 32'd0);
    axi_aresetn = 1'b1;
    tick();

    // Single read from requester 0, grant 3 cycles after pcie_req
    set_req(0, 1'b0, 32'h1000, 32'h0);
    tick();
    chk("rd.req_ready", 32'(req_ready), 32'd1);
    chk("rd.pcie_req_c1", 32'(pcie_req), 32'd1);
    chk("rd.pcie_wr", 32'(pcie_wr), 32'd0);
    chk("rd.pcie_addr", pcie_addr, 32'h1000);
    req_valid[0] = 1'b0;
    tick();
    chk("rd.req_ready_pulse", 32'(req_ready), 32'd0);
    chk("rd.pcie_req_c2", 32'(pcie_req), 32'd1);
    chk("rd.addr_hold", pcie_addr, 32'h1000);
    tick();
    chk("rd.pcie_req_c3", 32'(pcie_req), 32'd1);
    chk("rd.no_rsp_yet", 32'(rsp_valid), 32'd0);
    pcie_gnt   = 1'b1;
    pcie_rdata = 32'hDEADBEEF;
    tick();
    pcie_gnt = 1'b0;
    chk("rd.pcie_req_off", 32'(pcie_req), 32'd0);
    chk("rd.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd.rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd.rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    chk("rd.rsp_done", 32'(rsp_valid), 32'd0);

    // Simultaneous writes after reset: requester 0 first, then 1
    do_reset();
    set_req(0, 1'b1, 32'h10, 32'hA);
    set_req(1, 1'b1, 32'h20, 32'hB);
    txn("wr0", 0, 1'b1, 32'h10, 32'hA, 1, 32'h55, 1'b1);
    txn("wr1", 1, 1'b1, 32'h20, 32'hB, 1, 32'h66, 1'b1);

    // Continuous contention: grants alternate 0,1,0,1,0,1
    set_req(0, 1'b0, 32'h300, 32'h0);
    set_req(1, 1'b0, 32'h400, 32'h0);
    for (int k = 0; k < 6; k++) begin
      txn($sformatf("rr%0d", k), k % 2, 1'b0, (k % 2) ? 32'h400 : 32'h300, 32'h0, 1,
          32'h1111_0000 + 32'(k), 1'b0);
    end
    req_valid = '0;

    // Timeout on requester 1: abort after 4 ISSUE cycles
    set_req(1, 1'b0, 32'h40, 32'h0);
    tick();
    chk("to.req_ready", 32'(req_ready), 32'd2);
    chk("to.pcie_addr", pcie_addr, 32'h40);
    req_valid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("to.pcie_req_hold%0d", c), 32'(pcie_req), 32'd1);
    end
    tick();
    chk("to.pcie_req_off", 32'(pcie_req), 32'd0);
    chk("to.rsp_valid", 32'(rsp_valid), 32'd2);
    chk("to.rsp_err", 32'(rsp_err), 32'd1);
    chk("to.rsp_rdata", rsp_rdata, 32'h0);
    pcie_gnt   = 1'b1;
    pcie_rdata = 32'h1234;
    tick();
    pcie_gnt = 1'b0;
    chk("to.late_gnt_valid", 32'(rsp_valid), 32'd2);
    chk("to.late_gnt_err", 32'(rsp_err), 32'd1);
    chk("to.late_gnt_rdata", rsp_rdata, 32'h0);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;
    chk("to.rsp_done", 32'(rsp_valid), 32'd0);
    chk("to.err_clr", 32'(rsp_err), 32'd0);
    pcie_gnt = 1'b1;
    tick();
    pcie_gnt = 1'b0;
    chk("idle_gnt.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_gnt.pcie_req", 32'(pcie_req), 32'd0);

    // Grant on the terminal-count cycle completes normally
    set_req(0, 1'b0, 32'h80, 32'h0);
    txn("tc", 0, 1'b0, 32'h80, 32'h0, 4, 32'hCAFEF00D, 1'b1);

    // Response backpressure with requester 1 pending
    set_req(0, 1'b0, 32'h100, 32'h0);
    tick();
    chk("bp.req_ready", 32'(req_ready), 32'd1);
    req_valid[0] = 1'b0;
    set_req(1, 1'b0, 32'h200, 32'h0);
    pcie_gnt   = 1'b1;
    pcie_rdata = 32'h600D;
    tick();
    pcie_gnt = 1'b0;
    chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp.hold_valid%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp.hold_rdata%0d", c), rsp_rdata, 32'h600D);
      chk($sformatf("bp.no_issue%0d", c), 32'(pcie_req), 32'd0);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    chk("bp.rsp_done", 32'(rsp_valid), 32'd0);
    chk("bp.idle_no_req", 32'(pcie_req), 32'd0);
    tick();
    chk("bp.next_req", 32'(pcie_req), 32'd1);
    chk("bp.next_ready", 32'(req_ready), 32'd2);
    chk("bp.next_addr", pcie_addr, 32'h200);
    req_valid[1] = 1'b0;
    tick();

    // Asynchronous reset while a request is issued
    chk("mr.pcie_req_before", 32'(pcie_req), 32'd1);
    axi_aresetn = 1'b0;
    #1;
    chk("mr.pcie_req", 32'(pcie_req), 32'd0);
    chk("mr.pcie_addr", pcie_addr, 32'd0);
    chk("mr.rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    pcie_gnt = 1'b1;
    tick();
    pcie_gnt = 1'b0;
    chk("mr.no_rsp", 32'(rsp_valid), 32'd0);
    set_req(0, 1'b0, 32'h500, 32'h0);
    set_req(1, 1'b0, 32'h600, 32'h0);
    txn("mr.prio0", 0, 1'b0, 32'h500, 32'h0, 1, 32'h77, 1'b1);
    txn("mr.then1", 1, 1'b0, 32'h600, 32'h0, 2, 32'h88, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
